// File: rtl/machine_batch_scheduler.sv
// Fans machine jobs out to NUM_SOLVERS solver slots and sums their press counts per batch.
// Job reaches slv_start 2 cycles after acceptance; in_ready drops when no slot is idle or a batch is draining/reporting.
module machine_batch_scheduler #(
    parameter int NUM_LIGHTS    = 10,
    parameter int NUM_BUTTONS   = 13,
    parameter int NUM_SOLVERS   = 4,
    parameter int NUM_PRESSES_W = (NUM_BUTTONS <= 1) ? 1 : $clog2(NUM_BUTTONS + 1),
    parameter int TOTAL_W       = 32,
    parameter int SLOT_W        = (NUM_SOLVERS <= 1) ? 1 : $clog2(NUM_SOLVERS)
) (
    input  logic                                                  clk,
    input  logic                                                  rst_n,
    input  logic                                                  in_valid,
    output logic                                                  in_ready,
    input  logic [NUM_BUTTONS-1:0][NUM_LIGHTS-1:0]                in_buttons,
    input  logic [NUM_LIGHTS-1:0]                                 in_target,
    input  logic                                                  in_last,
    output logic [NUM_SOLVERS-1:0]                                slv_rst_n,
    output logic [NUM_SOLVERS-1:0]                                slv_start,
    output logic [NUM_SOLVERS-1:0][NUM_BUTTONS-1:0][NUM_LIGHTS-1:0] slv_buttons,
    output logic [NUM_SOLVERS-1:0][NUM_LIGHTS-1:0]                slv_target,
    input  logic [NUM_SOLVERS-1:0]                                slv_ready,
    input  logic [NUM_SOLVERS-1:0][NUM_PRESSES_W-1:0]             slv_presses,
    output logic                                                  total_valid,
    input  logic                                                  total_ready,
    output logic [TOTAL_W-1:0]                                    total_presses,
    output logic [7:0]                                            unsolvable_count,
    output logic                                                  busy
);

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_RESET,
        SLOT_START,
        SLOT_BUSY
    } slot_state_t;

    typedef enum logic [1:0] {
        BATCH_ACCEPT,
        BATCH_DRAIN,
        BATCH_REPORT
    } batch_state_t;

    slot_state_t            slot_q [NUM_SOLVERS];
    slot_state_t            slot_d [NUM_SOLVERS];
    batch_state_t           batch_q;
    batch_state_t           batch_d;

    logic [SLOT_W-1:0]      rr_q;
    logic [SLOT_W-1:0]      rr_d;
    logic [SLOT_W-1:0]      grant_idx;
    logic                   grant_found;
    logic                   accept;

    logic [NUM_SOLVERS-1:0] slot_idle;
    logic [NUM_SOLVERS-1:0] slot_busy;
    logic [NUM_SOLVERS-1:0] slot_done;

    logic [TOTAL_W-1:0]     total_q;
    logic [TOTAL_W-1:0]     total_d;
    logic [TOTAL_W-1:0]     cycle_sum;
    logic [7:0]             unsolv_q;
    logic [7:0]             unsolv_d;
    logic [8:0]             unsolv_inc;
    logic [8:0]             unsolv_sum;
    logic [7:0]             spurious_done;
    logic                   spurious_hit;

    always_comb begin
        slot_idle = '0;
        slot_busy = '0;
        for (int i = 0; i < NUM_SOLVERS; i++) begin
            slot_idle[i] = (slot_q[i] == SLOT_IDLE);
            slot_busy[i] = (slot_q[i] == SLOT_BUSY);
        end
        slot_done    = slot_busy & slv_ready;
        spurious_hit = |(slv_ready & ~slot_busy);
    end

    // Gated by rst_n so the handshake is closed even before state has been reset.
    assign in_ready = rst_n && (batch_q == BATCH_ACCEPT) && (|slot_idle);
    assign accept   = in_valid && in_ready;

    // Round-robin search: first idle slot at or after rr, wrapping.
    always_comb begin
        logic [SLOT_W:0]   probe;
        logic [SLOT_W-1:0] idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        probe       = '0;
        idx         = '0;
        for (int k = 0; k < NUM_SOLVERS; k++) begin
            probe = {1'b0, rr_q} + (SLOT_W + 1)'(k);
            if (probe >= (SLOT_W + 1)'(NUM_SOLVERS)) begin
                probe = probe - (SLOT_W + 1)'(NUM_SOLVERS);
            end
            idx = probe[SLOT_W-1:0];
            if (!grant_found && slot_idle[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (accept && grant_found) begin
            rr_d = (grant_idx == SLOT_W'(NUM_SOLVERS - 1)) ? '0 : grant_idx + SLOT_W'(1);
        end
    end

    always_comb begin
        slv_start = '0;
        slv_rst_n = '1;
        for (int i = 0; i < NUM_SOLVERS; i++) begin
            slot_d[i]    = slot_q[i];
            slv_start[i] = rst_n && (slot_q[i] == SLOT_START);
            slv_rst_n[i] = rst_n && (slot_q[i] != SLOT_RESET);
            case (slot_q[i])
                SLOT_IDLE: begin
                    if (accept && grant_found && (grant_idx == SLOT_W'(i))) begin
                        slot_d[i] = SLOT_RESET;
                    end
                end
                SLOT_RESET: slot_d[i] = SLOT_START;
                SLOT_START: slot_d[i] = SLOT_BUSY;
                SLOT_BUSY: begin
                    if (slv_ready[i]) begin
                        slot_d[i] = SLOT_IDLE;
                    end
                end
                default: slot_d[i] = SLOT_IDLE;
            endcase
        end
    end

    // All slots finishing this cycle are folded in together; all-ones means unsolvable.
    always_comb begin
        cycle_sum  = '0;
        unsolv_inc = '0;
        for (int i = 0; i < NUM_SOLVERS; i++) begin
            if (slot_done[i]) begin
                if (slv_presses[i] == {NUM_PRESSES_W{1'b1}}) begin
                    unsolv_inc = unsolv_inc + 9'd1;
                end else begin
                    cycle_sum = cycle_sum + TOTAL_W'(slv_presses[i]);
                end
            end
        end
        unsolv_sum = {1'b0, unsolv_q} + unsolv_inc;
    end

    always_comb begin
        batch_d  = batch_q;
        total_d  = total_q + cycle_sum;
        unsolv_d = unsolv_sum[8] ? 8'hFF : unsolv_sum[7:0];
        case (batch_q)
            BATCH_ACCEPT: begin
                if (accept && in_last) begin
                    batch_d = BATCH_DRAIN;
                end
            end
            BATCH_DRAIN: begin
                if (&slot_idle) begin
                    batch_d = BATCH_REPORT;
                end
            end
            BATCH_REPORT: begin
                if (total_ready) begin
                    batch_d  = BATCH_ACCEPT;
                    total_d  = '0;
                    unsolv_d = '0;
                end
            end
            default: batch_d = BATCH_ACCEPT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            batch_q       <= BATCH_ACCEPT;
            rr_q          <= '0;
            total_q       <= '0;
            unsolv_q      <= '0;
            spurious_done <= '0;
            for (int i = 0; i < NUM_SOLVERS; i++) begin
                slot_q[i] <= SLOT_IDLE;
            end
        end else begin
            batch_q  <= batch_d;
            rr_q     <= rr_d;
            total_q  <= total_d;
            unsolv_q <= unsolv_d;
            if (spurious_hit && (spurious_done != 8'hFF)) begin
                spurious_done <= spurious_done + 8'd1;
            end
            for (int i = 0; i < NUM_SOLVERS; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slv_buttons <= '0;
            slv_target  <= '0;
        end else begin
            for (int i = 0; i < NUM_SOLVERS; i++) begin
                if (accept && grant_found && (grant_idx == SLOT_W'(i))) begin
                    slv_buttons[i] <= in_buttons;
                    slv_target[i]  <= in_target;
                end
            end
        end
    end

    assign total_valid      = rst_n && (batch_q == BATCH_REPORT);
    assign total_presses    = total_q;
    assign unsolvable_count = unsolv_q;
    assign busy             = rst_n && (!(&slot_idle) || (batch_q != BATCH_ACCEPT));

endmodule
